// File: rtl/psram_word_adapter_if.sv
// CPU-side single-beat bus of the PSRAM word adapter.
// The adapter takes the slave modport; the requester takes the master modport.
interface psram_word_adapter_if;
  logic        req;
  logic        we;
  logic [23:0] a;
  logic [1:0]  size;
  logic [31:0] d;
  logic [31:0] spo;
  logic        ready;
  logic        done;
  logic        err;

  modport master (output req, we, a, size, d, input spo, ready, done, err);
  modport slave  (input req, we, a, size, d, output spo, ready, done, err);
endinterface

// File: rtl/psram_word_adapter.sv
// Byte/halfword/word bus front end for the QPI PSRAM controller byte-stream protocol.
// Define PSRAM_TIMEOUT_EN to add a per-transaction watchdog of TIMEOUT_CYCLES clocks.
module psram_word_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                clk,
  input  logic                rst,
  psram_word_adapter_if.slave bus,
  output logic                mem_rd,
  output logic                mem_rend,
  output logic                mem_we,
  output logic                mem_wend,
  output logic [23:0]         mem_a,
  output logic [7:0]          mem_din,
  input  logic [7:0]          mem_dout,
  input  logic                mem_byte_available,
  input  logic                mem_ready_for_next_byte,
  input  logic                mem_ready
);
  typedef enum logic [2:0] {BOOT, IDLE, ISSUE, WAIT_BUSY, XFER, WAIT_DONE} state_t;

  state_t      state;
  logic        ready_r, done_r, err_r;
  logic [31:0] spo_r, d_l;
  logic        we_l;
  logic [2:0]  n, k, k_inc, req_n;
  logic        bav_q, rfnb_q;
  logic        bav_rise, rfnb_fall, edge_hit, complete, timeout_hit;

  // Zero means the request is illegal (size 3 or misaligned).
  function automatic logic [2:0] byte_count(input logic [1:0] sz, input logic [1:0] a_lo);
    case (sz)
      2'd0:    byte_count = 3'd1;
      2'd1:    byte_count = a_lo[0] ? 3'd0 : 3'd2;
      2'd2:    byte_count = (a_lo != 2'b00) ? 3'd0 : 3'd4;
      default: byte_count = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] wr_byte(input logic [31:0] dat, input logic [2:0] idx,
                                         input logic [2:0] cnt);
    logic [2:0] sel;
    sel = (idx >= cnt) ? cnt - 3'd1 : idx;
    case (sel[1:0])
      2'd0:    wr_byte = dat[7:0];
      2'd1:    wr_byte = dat[15:8];
      2'd2:    wr_byte = dat[23:16];
      default: wr_byte = dat[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] cur, input logic [1:0] idx,
                                           input logic [7:0] b);
    put_byte = cur;
    case (idx)
      2'd0:    put_byte[7:0]   = b;
      2'd1:    put_byte[15:8]  = b;
      2'd2:    put_byte[23:16] = b;
      default: put_byte[31:24] = b;
    endcase
  endfunction

  assign req_n     = byte_count(bus.size, bus.a[1:0]);
  assign k_inc     = k + 3'd1;
  assign bav_rise  = mem_byte_available & ~bav_q;
  assign rfnb_fall = ~mem_ready_for_next_byte & rfnb_q;
  assign edge_hit  = we_l ? rfnb_fall : bav_rise;
  assign complete  = mem_ready && (state == XFER || state == WAIT_DONE);

`ifdef PSRAM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt;
  logic        busy;
  assign busy = (state == WAIT_BUSY) || (state == XFER) || (state == WAIT_DONE);
  always_ff @(posedge clk) begin
    if (rst || !busy) tcnt <= '0;
    else              tcnt <= tcnt + 16'd1;
  end
  assign timeout_hit = busy && (tcnt == TO_LAST);
`else
  // The limit only matters when the watchdog is compiled in.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      spo_r    <= '0;
      mem_rd   <= 1'b0;
      mem_rend <= 1'b0;
      mem_we   <= 1'b0;
      mem_wend <= 1'b0;
      mem_a    <= '0;
      mem_din  <= '0;
      we_l     <= 1'b0;
      d_l      <= '0;
      n        <= '0;
      k        <= '0;
      bav_q    <= 1'b0;
      rfnb_q   <= 1'b0;
    end else begin
      bav_q  <= mem_byte_available;
      rfnb_q <= mem_ready_for_next_byte;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        BOOT: if (mem_ready) begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        IDLE: if (bus.req) begin
          if (req_n != 3'd0) begin
            ready_r <= 1'b0;
            we_l    <= bus.we;
            mem_a   <= bus.a;
            d_l     <= bus.d;
            n       <= req_n;
            k       <= '0;
            if (!bus.we) spo_r <= '0;
            state   <= ISSUE;
          end else begin
            err_r <= 1'b1;
          end
        end
        ISSUE: begin
          if (we_l) begin
            mem_din <= d_l[7:0];
            mem_we  <= 1'b1;
          end else begin
            mem_rd <= 1'b1;
          end
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!mem_ready) state <= XFER;
        XFER: if (edge_hit) begin
          k <= k_inc;
          if (we_l) mem_din <= wr_byte(d_l, k_inc, n);
          else      spo_r   <= put_byte(spo_r, k[1:0], mem_dout);
          // End strobe goes up on the last edge and is held until the controller idles.
          if (k_inc == n) begin
            if (we_l) mem_wend <= 1'b1;
            else      mem_rend <= 1'b1;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin end
        default: state <= BOOT;
      endcase
      // Evaluated after the edge handling so a coincident byte is counted first.
      if (complete) begin
        mem_rend <= 1'b0;
        mem_wend <= 1'b0;
        done_r   <= 1'b1;
        ready_r  <= 1'b1;
        state    <= IDLE;
      end
      if (timeout_hit) begin
        mem_rend <= 1'b0;
        mem_wend <= 1'b0;
        done_r   <= 1'b0;
        ready_r  <= 1'b0;
        err_r    <= 1'b1;
        state    <= BOOT;
      end
    end
  end

  assign bus.spo   = spo_r;
  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
endmodule

// File: tb/tb_psram_word_adapter.sv
// Directed bench for psram_word_adapter with a byte-level controller emulation and outcome model.
// The timeout scenario runs only when PSRAM_TIMEOUT_EN is defined.
module tb_psram_word_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psram_word_adapter_if bus();
  logic        mem_rd, mem_rend, mem_we, mem_wend;
  logic [23:0] mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_byte_available, mem_ready_for_next_byte, mem_ready;

  psram_word_adapter #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_rd(mem_rd), .mem_rend(mem_rend), .mem_we(mem_we), .mem_wend(mem_wend),
    .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_byte_available(mem_byte_available),
    .mem_ready_for_next_byte(mem_ready_for_next_byte), .mem_ready(mem_ready)
  );

  int total = 0;
  int bad = 0;

  // Reference memory (what the bus wrote) and the emulated device memory (what the controller got).
  logic [7:0]  ref_mem [0:255];
  logic [7:0]  emu_mem [0:255];
  bit          cmd_pending;
  int          pend_kind;      // 0 none, 1 done expected, 2 err expected
  bit          pend_read;
  logic [31:0] pend_spo, model_spo;
  int          cnt, waited;
  logic [31:0] seq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit w, input logic [23:0] addr, input logic [1:0] sz,
                        input logic [31:0] dat);
    int  n;
    bit  legal;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    legal = (sz != 2'd3) && !((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00));
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.a = addr; bus.size = sz; bus.d = dat;
    if (legal) begin
      cmd_pending = 1'b1;
      pend_kind   = 1;
      pend_read   = !w;
      pend_spo    = '0;
      for (int i = 0; i < n; i++) begin
        if (w) ref_mem[addr[7:0] + 8'(i)] = dat[8*i +: 8];
        else   pend_spo[8*i +: 8] = ref_mem[addr[7:0] + 8'(i)];
      end
    end else begin
      pend_kind = 2;
    end
    @(negedge clk);
    bus.req = 1'b0;
    if (!legal) begin
      check("err_next_cycle", 32'(bus.err), 32'd1);
      check("ready_kept_on_err", 32'(bus.ready), 32'd1);
    end else begin
      check("ready_drops_on_accept", 32'(bus.ready), 32'd0);
    end
  endtask

  // Plays the controller for one accepted command; cnt = strobe edges until the end strobe.
  task automatic serve(input logic [23:0] addr, output int c, output logic [31:0] s);
    bit         seen, w;
    logic [7:0] base;
    int         wt;
    c = 0; s = '0; seen = 1'b0; w = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd || mem_we) begin seen = 1'b1; w = mem_we; end
    end
    check("cmd_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check("mem_a", 32'(mem_a), 32'(addr));
    base = addr[7:0];
    mem_ready = 1'b0;
    if (w) begin
      s[7:0] = mem_din;
      emu_mem[base] = mem_din;
      while (c < 6) begin
        mem_ready_for_next_byte = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready_for_next_byte = 1'b0;
        c++;
        repeat (2) @(negedge clk);
        if (mem_wend) break;
        if (c < 4) s[8*c +: 8] = mem_din;
        emu_mem[base + 8'(c)] = mem_din;
      end
    end else begin
      while (c < 6) begin
        repeat (2) @(negedge clk);
        mem_dout = emu_mem[base + 8'(c)];
        mem_byte_available = 1'b1;
        repeat (2) @(negedge clk);
        mem_byte_available = 1'b0;
        c++;
        if (mem_rend) break;
      end
      @(negedge clk);
      mem_dout = 8'hFF;
      mem_byte_available = 1'b1;
      repeat (2) @(negedge clk);
      mem_byte_available = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("end_strobe_held", 32'(w ? mem_wend : mem_rend), 32'd1);
    mem_ready = 1'b1;
    wt = 0;
    while (!bus.done && wt < 4) begin @(negedge clk); wt++; end
    check("done_within_3", 32'(bus.done && wt <= 3), 32'd1);
    @(negedge clk);
    check("end_strobe_cleared", 32'(mem_rend | mem_wend), 32'd0);
  endtask

  // Per-cycle comparison of the DUT against the outcome model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_rd || mem_we) begin
          total++;
          if (!cmd_pending) begin
            bad++;
            $display("FAIL unexpected_cmd: rd=%0b we=%0b a=0x%06h with no accepted request", mem_rd, mem_we, mem_a);
          end
          cmd_pending = 1'b0;
        end
        if (bus.done) begin
          total++;
          if (pend_kind != 1) begin
            bad++;
            $display("FAIL done_pulse: got done=1 while expecting outcome %0d", pend_kind);
          end else if (pend_read) begin
            model_spo = pend_spo;
          end
          pend_kind = 0;
        end
        if (bus.err) begin
          total++;
          if (pend_kind != 2) begin
            bad++;
            $display("FAIL err_pulse: got err=1 while expecting outcome %0d", pend_kind);
          end
          pend_kind = 0;
        end
        if (bus.ready) check("spo_idle", bus.spo, model_spo);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 300000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.a = '0; bus.size = '0; bus.d = '0;
    mem_dout = '0; mem_byte_available = 1'b0; mem_ready_for_next_byte = 1'b0; mem_ready = 1'b0;
    cmd_pending = 1'b0; pend_kind = 0; pend_read = 1'b0; pend_spo = '0; model_spo = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; emu_mem[i] = '0; end

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    check("rst_spo", bus.spo, 32'd0);
    check("rst_mem_strobes", {28'd0, mem_rd, mem_rend, mem_we, mem_wend}, 32'd0);
    check("rst_mem_a_din", {mem_a, mem_din}, 32'd0);
    rst = 1'b0;

    // Requests during controller init are dropped.
    repeat (3) @(negedge clk);
    check("boot_ready_low", 32'(bus.ready), 32'd0);
    bus.req = 1'b1; bus.we = 1'b0; bus.a = 24'h000100; bus.size = 2'd2;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (4) @(negedge clk);
    check("boot_req_ignored", 32'(bus.ready), 32'd0);
    mem_ready = 1'b1;
    waited = 0;
    while (!bus.ready && waited < 5) begin @(negedge clk); waited++; end
    check("boot_exit_ready", 32'(bus.ready), 32'd1);

    do_req(1'b1, 24'h000100, 2'd2, 32'hDEADBEEF);
    serve(24'h000100, cnt, seq);
    check("w32_falls", cnt, 32'd4);
    check("w32_din_seq", seq, 32'hDEADBEEF);
    do_req(1'b0, 24'h000100, 2'd2, 32'd0);
    serve(24'h000100, cnt, seq);
    check("r32_rises", cnt, 32'd4);
    check("r32_spo", bus.spo, 32'hDEADBEEF);

    do_req(1'b1, 24'h000100, 2'd2, 32'h11223344);
    serve(24'h000100, cnt, seq);
    do_req(1'b1, 24'h000102, 2'd0, 32'h000000A5);
    serve(24'h000102, cnt, seq);
    check("w8_falls", cnt, 32'd1);
    check("w8_din", seq, 32'h000000A5);
    do_req(1'b0, 24'h000100, 2'd2, 32'd0);
    serve(24'h000100, cnt, seq);
    check("w8_readback", bus.spo, 32'h11A53344);

    ref_mem[8'h04] = 8'h34; ref_mem[8'h05] = 8'h12;
    emu_mem[8'h04] = 8'h34; emu_mem[8'h05] = 8'h12;
    do_req(1'b0, 24'h000104, 2'd1, 32'd0);
    serve(24'h000104, cnt, seq);
    check("r16_rend_on_rise", cnt, 32'd2);
    check("r16_spo", bus.spo, 32'h00001234);

    do_req(1'b1, 24'h000101, 2'd2, 32'h00000055);
    do_req(1'b0, 24'h000100, 2'd3, 32'd0);
    do_req(1'b0, 24'h000103, 2'd1, 32'd0);
    repeat (3) @(negedge clk);
    check("illegal_ready_stays", 32'(bus.ready), 32'd1);

    // A write pulsed mid-read must be ignored.
    do_req(1'b0, 24'h000100, 2'd2, 32'd0);
    fork
      serve(24'h000100, cnt, seq);
      begin
        repeat (6) @(negedge clk);
        check("busy_ready_low", 32'(bus.ready), 32'd0);
        bus.req = 1'b1; bus.we = 1'b1; bus.a = 24'h000108; bus.size = 2'd0; bus.d = 32'h77;
        @(negedge clk);
        bus.req = 1'b0;
      end
    join
    check("busy_read_spo", bus.spo, 32'h11A53344);
    do_req(1'b0, 24'h000108, 2'd0, 32'd0);
    serve(24'h000108, cnt, seq);
    check("busy_write_dropped", bus.spo, 32'd0);

`ifdef PSRAM_TIMEOUT_EN
    do_req(1'b0, 24'h000100, 2'd2, 32'd0);
    pend_kind = 2;
    waited = 0;
    while (!mem_rd && waited < 10) begin @(negedge clk); waited++; end
    mem_ready = 1'b0;
    waited = 0;
    while (!bus.err && waited < 80) begin @(negedge clk); waited++; end
    check("timeout_cycle", 32'(waited >= 49 && waited <= 51), 32'd1);
    repeat (3) @(negedge clk);
    check("timeout_back_to_boot", 32'(bus.ready), 32'd0);
    check("timeout_rend_low", 32'(mem_rend), 32'd0);
    mem_ready = 1'b1;
    waited = 0;
    while (!bus.ready && waited < 5) begin @(negedge clk); waited++; end
    check("timeout_ready_again", 32'(bus.ready), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psram_word_adapter.md
Name: psram_word_adapter

Overview:
- CPU-side front end that sits directly upstream of the QPI PSRAM controller (ESP-PSRAM64H).
- Converts single-beat byte, halfword and word bus requests into the controller's byte-stream protocol:
  - read: rd/rend with dout/byte_available;
  - write: we/wend with din/ready_for_next_byte.
- Assembles or serialises little-endian data and reports completion to the bus.
- Runs in the memory clock domain, on the same clock as the controller.

Parameters:
- TIMEOUT_CYCLES, 4095: watchdog limit in clocks per transaction (used only with the optional feature).

Ports:
- clk  in  1  memory clock, same clock as the controller
- rst  in  1  synchronous, active-high reset
- req  in  1  one-cycle request strobe, accepted only while ready=1
- we  in  1  1 = write, 0 = read (sampled with req)
- a  in  24  byte address (sampled with req)
- size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal
- d  in  32  write data, little-endian, right-aligned (sampled with req)
- spo  out  32  read data, right-aligned, zero-extended
- ready  out  1  adapter idle and able to accept req
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse (misaligned, illegal size, or timeout)
- mem_rd  out  1  to controller rd
- mem_rend  out  1  to controller rend
- mem_we  out  1  to controller we
- mem_wend  out  1  to controller wend
- mem_a  out  24  to controller a
- mem_din  out  8  to controller din
- mem_dout  in  8  from controller dout
- mem_byte_available  in  1  from controller
- mem_ready_for_next_byte  in  1  from controller
- mem_ready  in  1  controller idle

Behaviour:
- Reset values:
  - all outputs 0, except ready;
  - ready=0 until BOOT exits;
  - spo=0.
  - Reset mid-transaction abandons it immediately; no done or err is produced.
- Byte count N:
  - size 0 → N=1, size 1 → N=2, size 2 → N=4.
  - Alignment rule: a[0]=0 for size 1; a[1:0]=0 for size 2.
  - Violation, or size=3: err pulses the cycle after req, no memory access is made, ready stays 1.
- Edge detectors:
  - Registered edge detection on mem_byte_available (rising) and mem_ready_for_next_byte (falling).
  - Both strobes are multi-cycle levels, so only edges are counted.
- State machine:
  - BOOT: wait for the first mem_ready=1, then go to IDLE. Controller init takes about 20000 clocks.
  - IDLE:
    - ready=1.
    - On a legal req: latch a, we, N, d; clear byte index k and spo shift register; go to ISSUE.
  - ISSUE:
    - Drive mem_a=a.
    - Write: mem_din=d[7:0]; pulse mem_we for 1 cycle.
    - Read: pulse mem_rd for 1 cycle.
    - Go to WAIT_BUSY.
  - WAIT_BUSY: wait for mem_ready=0, then go to XFER. mem_a is held for the whole transaction.
  - XFER, read:
    - On each byte_available rise: capture mem_dout into byte k of spo, then k++.
    - On the rise where k reaches N: set mem_rend=1 and hold it until mem_ready=1.
    - Any further rises before mem_ready=1 (controller overrun) are ignored.
  - XFER, write:
    - On each ready_for_next_byte fall: k++, and mem_din = d byte k.
    - Bytes beyond N-1 repeat byte N-1 (don't-care).
    - On the fall where k reaches N: set mem_wend=1 and hold it until mem_ready=1.
  - WAIT_DONE: mem_ready=1 → clear mem_rend/mem_wend, pulse done, go to IDLE. spo stays valid until the next accepted read.
- Latency: done arrives no earlier than the controller's return to IDLE. The adapter adds at most 3 clocks over the controller's own latency.
- Simultaneous events:
  - req while ready=0 is ignored; no queueing.
  - A byte_available edge coinciding with mem_ready=1 is counted before completion is evaluated.
- Write with N=1: mem_wend is raised on the first fall, which occurs before the controller's data phase. The hold-until-ready rule keeps it asserted into that phase.

Optional Feature:
- Macro: PSRAM_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter runs in WAIT_BUSY, XFER and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES: deassert mem_rend/mem_wend, pulse err (no done), go to BOOT and wait for mem_ready=1 again.
- Without the macro: no counter; the adapter waits indefinitely.

Test Plan:
- Word write then read-back:
  - Write a=0x000100, size=2, d=0xDEADBEEF; then read the same address.
  - Required: mem_din sequence EF, BE, AD, DE; both transactions produce done; spo=0xDEADBEEF.
- Byte write then word read:
  - Write size=0 at a=0x000102, d=0x000000A5 into a word pre-filled 0x11223344.
  - Required: word read returns 0x11A53344; exactly 1 falling edge of mem_din advance before mem_wend.
- Halfword read:
  - Read size=1 at a=0x000104 holding bytes 0x34, 0x12.
  - Required: spo=0x00001234; mem_rend asserted on the 2nd byte_available rise.
- Misaligned and illegal requests:
  - Issue size=2 at a=0x000101, and separately size=3.
  - Required: err pulses 1 cycle after req; mem_rd/mem_we never assert; ready stays 1.
- Boot and busy rejection:
  - Pulse req during BOOT, and again while mid-transfer.
  - Required: both ignored; only the accepted transaction produces done.
- Timeout (PSRAM_TIMEOUT_EN, TIMEOUT_CYCLES=50):
  - Hold mem_ready=0 with no byte strobes.
  - Required: err at cycle 50; adapter returns to BOOT; ready=1 after mem_ready rises.
